// File: rtl/note_lane_dropper.sv
// Single-lane note dropper: spawns a scheduled series of falling notes, grades
// lane-key presses against a hit window, and keeps score and combo.
// Optional: define NOTE_LANE_PERFECT_EN to enable perfect grading (+2 and perfect_pulse).
module note_lane_dropper #(
  parameter int          X_POS       = 100,
  parameter int          Y_START     = 100,
  parameter int          Y_MAX       = 400,
  parameter int          NOTE_H      = 40,
  parameter int          SPEED       = 1,
  parameter int          HIT_LO      = 340,
  parameter int          PERF_LO     = 360,
  parameter int          PERF_HI     = 380,
  parameter logic [7:0]  LANE_KEY    = 8'h1a,
  parameter logic [7:0]  START_KEY   = 8'h2c,
  parameter logic [7:0]  RESTART_KEY = 8'h01,
  parameter int          NUM_SLOTS   = 4,
  parameter int          NUM_NOTES   = 4,
  parameter int          DELAY       = 10,
  parameter int          INTERVAL    = 50
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [7:0]              keycode_second,
  output logic [9:0]              lane_x,
  output logic [10*NUM_SLOTS-1:0] note_y,
  output logic [NUM_SLOTS-1:0]    note_active,
  output logic                    hit_pulse,
  output logic                    perfect_pulse,
  output logic                    miss_pulse,
  output logic [7:0]              score,
  output logic [7:0]              combo,
  output logic                    done,
  output logic [1:0]              state_dbg
);

`ifdef NOTE_LANE_PERFECT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {HALTED = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            next_spawn_q, next_spawn_d;
  logic [15:0]            idx_q, idx_d;
  logic [9:0]             y_q [NUM_SLOTS];
  logic [9:0]             y_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   act_q, act_d;
  logic                   hit_q, hit_d, perf_q, perf_d, miss_q, miss_d;
  logic [7:0]             score_q, score_d, combo_q, combo_d;
  logic                   done_q, done_d;
  logic                   lane_prev_q, lane_prev_d;

  logic                   lane_now, press, start_key, restart_key;
  logic [10:0]            bot [NUM_SLOTS];
  logic                   best_found, taken, free_found, in_perf;
  logic [10:0]            best_bot;
  logic [8:0]             sum9;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    next_spawn_d = next_spawn_q;
    idx_d        = idx_q;
    y_d          = y_q;
    act_d        = act_q;
    score_d      = score_q;
    combo_d      = combo_q;
    done_d       = done_q;
    hit_d        = 1'b0;
    perf_d       = 1'b0;
    miss_d       = 1'b0;
    best_found   = 1'b0;
    best_bot     = '0;
    taken        = 1'b0;
    free_found   = 1'b0;
    in_perf      = 1'b0;
    sum9         = '0;
    lane_now     = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
    start_key    = (keycode == START_KEY) || (keycode_second == START_KEY);
    restart_key  = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);
    press        = lane_now & ~lane_prev_q;
    lane_prev_d  = lane_now;
    for (int i = 0; i < NUM_SLOTS; i++) bot[i] = {1'b0, y_q[i]} + 11'(NOTE_H);

    case (state_q)
      HALTED: begin
        cnt_d        = '0;
        next_spawn_d = 16'(DELAY);
        idx_d        = '0;
        act_d        = '0;
        score_d      = '0;
        combo_d      = '0;
        done_d       = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) y_d[i] = 10'(Y_START);
        if (start_key) state_d = PLAY;
      end
      PLAY: begin
        // Grading uses start-of-frame slot contents only.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (act_q[i]) begin
            if (bot[i] >= 11'(Y_MAX)) begin
              act_d[i] = 1'b0;
              y_d[i]   = 10'(Y_START);
              miss_d   = 1'b1;
            end else begin
              y_d[i] = y_q[i] + 10'(SPEED);
              if (bot[i] >= 11'(HIT_LO) && (!best_found || bot[i] > best_bot)) begin
                best_found = 1'b1;
                best_bot   = bot[i];
              end
            end
          end
        end
        in_perf = (best_bot >= 11'(PERF_LO)) && (best_bot < 11'(PERF_HI));
        if (press && best_found) begin
          hit_d  = 1'b1;
          perf_d = PERF_EN & in_perf;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!taken && act_q[i] && bot[i] == best_bot) begin
              taken    = 1'b1;
              act_d[i] = 1'b0;
              y_d[i]   = 10'(Y_START);
            end
          end
        end
        // Spawn looks at act_q so a slot freed this frame is not reused yet.
        if (idx_q < 16'(NUM_NOTES) && cnt_q == next_spawn_q) begin
          idx_d        = idx_q + 16'd1;
          next_spawn_d = next_spawn_q + 16'(INTERVAL);
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && !act_q[i]) begin
              free_found = 1'b1;
              act_d[i]   = 1'b1;
              y_d[i]     = 10'(Y_START);
            end
          end
          if (!free_found) miss_d = 1'b1;
        end
        if (idx_q < 16'(NUM_NOTES)) cnt_d = cnt_q + 16'd1;
        sum9 = {1'b0, score_q} + (perf_d ? 9'd2 : 9'd1);
        if (hit_d) score_d = sum9[8] ? 8'hff : sum9[7:0];
        if (miss_d)                         combo_d = '0;
        else if (hit_d && combo_q != 8'hff) combo_d = combo_q + 8'd1;
        if (idx_d == 16'(NUM_NOTES) && act_d == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (restart_key) begin
          state_d = HALTED;
          score_d = '0;
          combo_d = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= HALTED;
      cnt_q        <= '0;
      next_spawn_q <= 16'(DELAY);
      idx_q        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) y_q[i] <= 10'(Y_START);
      act_q        <= '0;
      hit_q        <= 1'b0;
      perf_q       <= 1'b0;
      miss_q       <= 1'b0;
      score_q      <= '0;
      combo_q      <= '0;
      done_q       <= 1'b0;
      lane_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      next_spawn_q <= next_spawn_d;
      idx_q        <= idx_d;
      y_q          <= y_d;
      act_q        <= act_d;
      hit_q        <= hit_d;
      perf_q       <= perf_d;
      miss_q       <= miss_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      done_q       <= done_d;
      lane_prev_q  <= lane_prev_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) note_y[10*i +: 10] = y_q[i];
  end

  assign lane_x        = 10'(X_POS);
  assign note_active   = act_q;
  assign hit_pulse     = hit_q;
  assign perfect_pulse = perf_q;
  assign miss_pulse    = miss_q;
  assign score         = score_q;
  assign combo         = combo_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_note_lane_dropper.sv
// Bench for note_lane_dropper: directed scenarios plus random keys, checked every
// frame against a reference that derives note positions from spawn time.
module tb_note_lane_dropper;
  localparam int NS = 4, NN = 4, YS = 100, YM = 400, NH = 40, SP = 1;
  localparam int HL = 340, PL = 360, PH = 380, DL = 10, IV = 50;
  localparam logic [7:0] LK = 8'h1a, SK = 8'h2c, RK = 8'h01;
`ifdef NOTE_LANE_PERFECT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b0;
  logic [7:0]    keycode = 8'h00, keycode_second = 8'h00;
  logic [9:0]    lane_x;
  logic [10*NS-1:0] note_y;
  logic [NS-1:0] note_active;
  logic          hit_pulse, perfect_pulse, miss_pulse, done;
  logic [7:0]    score, combo;
  logic [1:0]    state_dbg;

  note_lane_dropper dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
    .lane_x(lane_x), .note_y(note_y), .note_active(note_active), .hit_pulse(hit_pulse),
    .perfect_pulse(perfect_pulse), .miss_pulse(miss_pulse), .score(score), .combo(combo),
    .done(done), .state_dbg(state_dbg)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0, checks = 0;
  int m_state, m_cnt, m_idx, m_edge = 0, m_score, m_combo;
  bit m_prev, e_hit, e_perf, e_miss;
  bit m_used [NS];
  int m_spawn [NS];
  int n_hit = 0;
  int miss_edges [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Top-edge Y of the note in slot s as seen after edge e.
  function automatic int y_of(int s, int e);
    return YS + SP * (e - m_spawn[s]);
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_combo = 0; m_prev = 0;
    e_hit = 0; e_perf = 0; e_miss = 0;
    for (int s = 0; s < NS; s++) m_used[s] = 0;
  endtask

  task automatic model_step(input logic [7:0] k1, input logic [7:0] k2);
    bit lane, press, any;
    bit was [NS];
    int best, bb, bot, free_s;
    m_edge++;
    lane = (k1 == LK) || (k2 == LK);
    press = lane && !m_prev;
    m_prev = lane;
    e_hit = 0; e_perf = 0; e_miss = 0;
    case (m_state)
      0: begin
        m_score = 0; m_combo = 0;
        for (int s = 0; s < NS; s++) m_used[s] = 0;
        if (k1 == SK || k2 == SK) begin m_state = 1; m_cnt = 0; m_idx = 0; end
      end
      1: begin
        for (int s = 0; s < NS; s++) was[s] = m_used[s];
        best = -1; bb = 0;
        for (int s = 0; s < NS; s++) begin
          if (was[s]) begin
            bot = y_of(s, m_edge - 1) + NH;
            if (bot >= YM) begin m_used[s] = 0; e_miss = 1; end
            else if (bot >= HL && bot > bb) begin best = s; bb = bot; end
          end
        end
        if (press && best >= 0) begin
          m_used[best] = 0; e_hit = 1;
          e_perf = PERF && bb >= PL && bb < PH;
        end
        if (m_idx < NN && m_cnt == DL + m_idx * IV) begin
          m_idx++;
          free_s = -1;
          for (int s = NS - 1; s >= 0; s--) if (!was[s]) free_s = s;
          if (free_s >= 0) begin m_used[free_s] = 1; m_spawn[free_s] = m_edge; end
          else e_miss = 1;
        end
        m_cnt++;
        if (e_hit) m_score = (m_score + (e_perf ? 2 : 1) > 255) ? 255 : m_score + (e_perf ? 2 : 1);
        if (e_miss) m_combo = 0;
        else if (e_hit) m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
        any = 0;
        for (int s = 0; s < NS; s++) any |= m_used[s];
        if (m_idx == NN && !any) m_state = 2;
      end
      default: if (k1 == RK || k2 == RK) begin m_state = 0; m_score = 0; m_combo = 0; end
    endcase
  endtask

  task automatic check_outputs();
    logic [NS-1:0] em;
    em = '0;
    for (int s = 0; s < NS; s++) begin
      em[s] = m_used[s];
      if (m_used[s]) check("note_y", note_y[10*s +: 10], y_of(s, m_edge));
    end
    check("note_active", note_active, em);
    check("hit_pulse", hit_pulse, e_hit);
    check("perfect_pulse", perfect_pulse, e_perf);
    check("miss_pulse", miss_pulse, e_miss);
    check("score", score, m_score);
    check("combo", combo, m_combo);
    check("done", done, m_state == 2);
  endtask

  task automatic frame(input logic [7:0] k1, input logic [7:0] k2);
    keycode = k1; keycode_second = k2;
    @(posedge frame_clk);
    model_step(k1, k2);
    #1;
    check_outputs();
    if (hit_pulse === 1'b1) n_hit++;
    if (miss_pulse === 1'b1) miss_edges.push_back(m_edge);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_active", note_active, 0);
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_done", done, 0);
    check("rst_pulses", {hit_pulse, perfect_pulse, miss_pulse}, 0);
    for (int s = 0; s < NS; s++) check("rst_y", note_y[10*s +: 10], YS);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic run_until_done(input int max_frames);
    int i;
    i = 0;
    while (done !== 1'b1 && i < max_frames) begin frame(8'h00, 8'h00); i++; end
    check("done_reached", done, 1);
  endtask

  task automatic wait_bottom(input int s, input int target, input int max_frames);
    int i;
    i = 0;
    while (!(m_used[s] && y_of(s, m_edge) + NH == target) && i < max_frames) begin
      frame(8'h00, 8'h00); i++;
    end
    check("reach_bottom", note_y[10*s +: 10] + NH, target);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 15);
    if (r < 4) return LK;
    if (r == 4) return SK;
    if (r == 5) return RK;
    if (r < 8) return 8'($urandom_range(0, 255));
    return 8'h00;
  endfunction

  initial begin
    int h0;
    do_reset();
    check("lane_x", lane_x, 100);
    for (int i = 0; i < 100; i++) frame(8'h00, 8'h00);
    check("idle_active", note_active, 0);
    check("idle_score", score, 0);
    check("idle_done", done, 0);

    // No lane key: every note is missed, 50 frames apart.
    frame(SK, 8'h00);
    miss_edges.delete();
    run_until_done(600);
    check("miss_count", miss_edges.size(), 4);
    for (int i = 1; i < miss_edges.size(); i++)
      check("miss_spacing", miss_edges[i] - miss_edges[i-1], 50);
    check("miss_score", score, 0);
    check("miss_combo", combo, 0);
    repeat (3) frame(8'h00, 8'h00);
    frame(8'h00, RK);
    check("restart_done", done, 0);

    // Single press at bottom 370.
    frame(SK, 8'h00);
    wait_bottom(0, 370, 400);
    frame(LK, 8'h00);
    check("perf_hit", hit_pulse, 1);
    check("perf_pulse", perfect_pulse, PERF);
    check("perf_score", score, PERF ? 2 : 1);
    check("perf_combo", combo, 1);
    run_until_done(600);
    do_reset();

    // keycode_second press at bottom 345, then held.
    frame(SK, 8'h00);
    wait_bottom(0, 345, 400);
    h0 = n_hit;
    frame(8'h00, LK);
    check("good_hit", hit_pulse, 1);
    check("good_perf", perfect_pulse, 0);
    check("good_score", score, 1);
    repeat (60) frame(8'h00, LK);
    check("held_no_rehit", n_hit - h0, 1);
    do_reset();

    // Two notes in the window: the lower one is taken.
    frame(SK, 8'h00);
    wait_bottom(0, 390, 400);
    check("note1_bottom", note_y[19:10] + NH, 340);
    frame(LK, 8'h00);
    check("two_slot0", note_active[0], 0);
    check("two_slot1", note_active[1], 1);
    check("two_y1", note_y[19:10], 301);
    do_reset();

    // Reset mid-play, then a full rerun.
    frame(SK, 8'h00);
    repeat (150) frame(8'h00, 8'h00);
    do_reset();
    frame(8'h00, 8'h00);
    check("midrst_active", note_active, 0);
    check("midrst_score", score, 0);
    frame(SK, 8'h00);
    miss_edges.delete();
    run_until_done(600);
    check("rerun_miss_count", miss_edges.size(), 4);

    // Random key traffic.
    for (int run = 0; run < 4; run++) begin
      do_reset();
      frame(SK, 8'h00);
      for (int i = 0; i < 700; i++) begin
        if ($urandom_range(0, 499) == 0) do_reset();
        else frame(rand_key(), rand_key());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/note_lane_dropper.md
# note_lane_dropper

Parametrised single-lane note dropper for the rhythm game. It replaces the one-arrow-per-module dropper instances. One instance owns one lane and releases a scheduled series of notes that fall through a configurable number of concurrent slots. It grades key presses against a hit window (perfect/good) and keeps score and combo. Its outputs feed the lane renderer (per-slot Y and active mask) and the scoreboard.

## Interface
Parameters:
- X_POS, 100: lane X position (pixels)
- Y_START, 100: spawn Y (top edge)
- Y_MAX, 400: bottom-edge miss line
- NOTE_H, 40: note height
- SPEED, 1: pixels moved per frame
- HIT_LO, 340: lowest bottom edge accepted as a hit (window is HIT_LO ≤ bottom < Y_MAX)
- PERF_LO, 360 / PERF_HI, 380: perfect sub-window, PERF_LO ≤ bottom < PERF_HI
- LANE_KEY, 8'h1a; START_KEY, 8'h2c; RESTART_KEY, 8'h01: keycodes
- NUM_SLOTS, 4: concurrent notes in flight
- NUM_NOTES, 4: notes per run
- DELAY, 10: frames before first spawn
- INTERVAL, 50: frames between spawns

Ports (one clock; reset is asynchronous and active-high):
- frame_clk  in  1  frame clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- keycode, keycode_second  in  8 each  current USB keycodes
- lane_x  out  10  constant X_POS
- note_y  out  10*NUM_SLOTS  top-edge Y per slot, slot i at [10i+9:10i]
- note_active  out  NUM_SLOTS  slot occupied (renderer draws only these)
- hit_pulse, perfect_pulse, miss_pulse  out  1 each  one-frame event pulses
- score  out  8  saturating at 255
- combo  out  8  consecutive hits, saturating at 255
- done  out  1  run finished

## Operation
- States: HALTED, PLAY, DONE.
- HALTED:
  - Frame counter, spawn index, slots, score and combo are held at 0.
  - START_KEY on either keycode input moves the FSM to PLAY on the next edge.
- PLAY:
  - The frame counter starts at 0 and increments every frame.
  - When counter == DELAY + k·INTERVAL (k < NUM_NOTES), note k is loaded into the lowest-index free slot with y = Y_START.
  - If no slot is free, the note is discarded: it counts as a miss and combo is cleared.
- Key press is a rising edge: LANE_KEY is present on either input this frame and was absent on both inputs last frame. Held keys score nothing further.
- Per frame, evaluated on start-of-frame slot contents. Bottom edge is y + NOTE_H, computed at 11 bits.
  - Miss: bottom ≥ Y_MAX → slot cleared, miss_pulse, combo cleared. Several misses in one frame produce one pulse.
  - Hit: on a press, the one active slot in the hit window with the largest bottom is cleared. hit_pulse is raised and combo is incremented.
  - Perfect hit (bottom in the perfect sub-window): score +2 and perfect_pulse.
  - Good hit: score +1.
  - A press with no note in the window has no effect.
  - All other active slots: y += SPEED.
- Slots freed this frame are not reused for a spawn in the same frame.
- PLAY → DONE when all NUM_NOTES have been issued and no slot is active.
- DONE: done = 1, and score and combo are held. RESTART_KEY → HALTED, which clears score and combo.

## Timing
- All outputs are registered.
- Reset values: state HALTED, note_y all Y_START, note_active 0, all pulses 0, score 0, combo 0, done 0. lane_x is constant.
- A key edge in frame n is graded on edge n. Pulses are high for exactly frame n+1.
- A spawned note appears in note_active one frame after its scheduled count. It moves SPEED per frame from the following frame.
- With the defaults, a note spawned at y=100 reaches the hit window 200 frames later and is missed 260 frames later.
- Reset mid-PLAY or mid-DONE: immediate return to HALTED. No pulse is emitted.
- Score and combo saturate; they never wrap.

## Configuration
- NOTE_LANE_PERFECT_EN defined: perfect grading as above.
- Not defined:
  - perfect_pulse is tied 0.
  - Every hit in the hit window scores +1.
  - PERF_LO and PERF_HI are ignored.

## Test plan
- Reset asserted, then keycode = 8'h00 for 100 frames → HALTED; note_active = 0, score = 0, done = 0.
- 8'h2c, then no lane key → 4 miss_pulses, spaced 50 frames apart; score = 0, combo = 0; done = 1 after the 4th miss.
- 8'h2c; single 8'h1a edge when note 0 bottom = 370 → hit_pulse + perfect_pulse, score = 2, combo = 1. Without the macro, score = 1 and perfect_pulse = 0.
- keycode_second = 8'h1a edge at bottom 345 → good hit, score = 1. Holding the key through the rest of the window gives no further hits.
- Notes 0 and 1 in the window at the same time (bottoms 390 and 340), one press → only slot 0 is cleared. Note 1 is still active at y = 301 on the following frame.
- Reset pulsed 150 frames into PLAY → next frame HALTED, note_active = 0, score = 0; 8'h2c restarts the full sequence.
